// File: rtl/rf_pkg.sv
// Shared register-file constants and the dump sequencer state encoding.
package rf_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    SEND0 = 3'd2,
    SEND1 = 3'd3,
    DONE  = 3'd4
  } rf_dump_state_t;

endpackage

// File: rtl/rf_dump_ctrl_if.sv
// Register dump stream: one (address, data) pair per beat.
// Valid/ready: a beat transfers on a rising edge where OutValid && OutReady; once
// OutValid rises it stays high with OutAddr/OutData frozen until that transfer.
interface rf_dump_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              OutValid;
    logic              OutReady;
    logic [ADDR_W-1:0] OutAddr;
    logic [DATA_W-1:0] OutData;

    modport master (
        output OutValid,
        output OutAddr,
        output OutData,
        input  OutReady
    );

    modport slave (
        input  OutValid,
        input  OutAddr,
        input  OutData,
        output OutReady
    );
endinterface

// File: rtl/rf_dump_ctrl.sv
// Register-file read sequencer: reads registers in even/odd pairs and streams them out.
// Optional macro RF_DUMP_SKIP_ZERO_EN suppresses the beat for hardwired register 0.
module rf_dump_ctrl
    import rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DATA_W   = RF_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                Start,
    output logic [ADDR_W-1:0]   ReadAddress1,
    output logic [ADDR_W-1:0]   ReadAddress2,
    input  logic [DATA_W-1:0]   ReadData1,
    input  logic [DATA_W-1:0]   ReadData2,
    rf_dump_ctrl_if.master      outIf,
    output logic                Busy,
    output logic                Done,
    output rf_dump_state_t      DbgState
);

`ifdef RF_DUMP_SKIP_ZERO_EN
    localparam bit SkipZero = 1'b1;
`else
    localparam bit SkipZero = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

    rf_dump_state_t    state;
    logic [ADDR_W-2:0] pairIdx;
    logic [ADDR_W-2:0] nextPair;
    logic [DATA_W-1:0] hold0;
    logic [DATA_W-1:0] hold1;
    logic [ADDR_W-1:0] evenAddr;
    logic [ADDR_W-1:0] oddAddr;
    logic              handshake;

    assign evenAddr  = {pairIdx, 1'b0};
    assign oddAddr   = {pairIdx, 1'b1};
    assign nextPair  = pairIdx + 1'b1;
    assign handshake = outIf.OutValid && outIf.OutReady;
    assign DbgState  = state;

    // Data comes straight from the holding registers, so a stalled beat cannot change
    // even if the register file is written behind it.
    always_comb begin
        outIf.OutData = '0;
        if (outIf.OutValid) begin
            outIf.OutData = (state == SEND1) ? hold1 : hold0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pairIdx        <= '0;
            hold0          <= '0;
            hold1          <= '0;
            ReadAddress1   <= '0;
            ReadAddress2   <= '0;
            outIf.OutValid <= 1'b0;
            outIf.OutAddr  <= '0;
            Busy           <= 1'b0;
            Done           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state        <= READ;
                        pairIdx      <= '0;
                        ReadAddress1 <= '0;
                        ReadAddress2 <= ADDR_W'(1);
                        Busy         <= 1'b1;
                    end
                end
                READ: begin
                    hold0          <= ReadData1;
                    hold1          <= ReadData2;
                    outIf.OutValid <= 1'b1;
                    if (SkipZero && (pairIdx == '0)) begin
                        state         <= SEND1;
                        outIf.OutAddr <= oddAddr;
                    end else begin
                        state         <= SEND0;
                        outIf.OutAddr <= evenAddr;
                    end
                end
                SEND0: begin
                    if (handshake) begin
                        state         <= SEND1;
                        outIf.OutAddr <= oddAddr;
                    end
                end
                SEND1: begin
                    if (handshake) begin
                        outIf.OutValid <= 1'b0;
                        // Terminate on the address compare; the pair counter never wraps.
                        if (oddAddr == LastAddr) begin
                            state        <= DONE;
                            Busy         <= 1'b0;
                            Done         <= 1'b1;
                            ReadAddress1 <= '0;
                            ReadAddress2 <= '0;
                        end else begin
                            state        <= READ;
                            pairIdx      <= nextPair;
                            ReadAddress1 <= {nextPair, 1'b0};
                            ReadAddress2 <= {nextPair, 1'b1};
                        end
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rf_dump_ctrl.md
# rf_dump_ctrl

Read-side sequencer for the register file. On a start pulse it drives the register file's two read ports through every register address and streams each (address, data) pair out on a valid/ready interface, one register per beat. It feeds debug, trace and checkpoint logic, and it never touches the register file write port.

## Interface
Parameters:
- NUM_REGS, 32, number of registers to dump; must be even and at most 2**ADDR_W
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Start  in  1  begin a dump; sampled only in IDLE
- ReadAddress1  out  ADDR_W  to register file read port 1 (even address)
- ReadAddress2  out  ADDR_W  to register file read port 2 (odd address)
- ReadData1  in  DATA_W  combinational read data for ReadAddress1
- ReadData2  in  DATA_W  combinational read data for ReadAddress2
- OutValid  out  1  stream beat valid
- OutReady  in  1  stream sink ready
- OutAddr  out  ADDR_W  register address of current beat
- OutData  out  DATA_W  register contents of current beat
- Busy  out  1  dump in progress (READ/SEND0/SEND1)
- Done  out  1  one-cycle pulse after last beat accepted

## Operation
- Register file read is asynchronous. Data for the addresses driven in a cycle is valid before that cycle's closing edge.
- FSM states: IDLE, READ, SEND0, SEND1, DONE.
- IDLE: read addresses are driven to 0. If Start=1, go to READ with pair index k=0.
- READ: drive ReadAddress1=2k and ReadAddress2=2k+1. Capture ReadData1 and ReadData2 into two holding registers at the edge. Go to SEND0.
- SEND0: OutValid=1, OutAddr=2k, OutData=hold0. On OutValid&&OutReady, go to SEND1. Otherwise hold all outputs stable.
- SEND1: same as SEND0, with OutAddr=2k+1 and OutData=hold1. On handshake: if 2k+1==NUM_REGS-1, go to DONE; otherwise k<=k+1 and go to READ.
- DONE: Done=1 for exactly one cycle, then go to IDLE.
- The register file is read exactly once per pair. Holding registers isolate the stream from later register-file writes, so the value emitted is the value read in that pair's READ cycle.
- Start outside IDLE (including DONE) is ignored; it is not queued.
- The pair counter has width ADDR_W-1 and never wraps; termination is on the address compare.
- OutValid, once raised, stays high with OutAddr and OutData unchanged until accepted.
- Reset values (asserted asynchronously, mid-dump included): state IDLE, k=0, holding registers 0, ReadAddress1/2=0, OutValid=0, OutAddr=0, OutData=0, Busy=0, Done=0. Any partial dump is abandoned and no beats are replayed.

## Timing
- Start sampled high at edge 0. READ occupies cycle 1. The first beat (addr 0) is valid in cycle 2.
- With OutReady held at 1: each pair takes 3 cycles (READ, SEND0, SEND1). The last beat (addr NUM_REGS-1) is valid in cycle 3·NUM_REGS/2. Done is high in the next cycle (cycle 49 for NUM_REGS=32).
- Each cycle OutReady is low in SEND0/SEND1 adds one cycle of latency.
- Busy is high from cycle 1 through the last SEND1 cycle, and low in DONE and IDLE.
- A new Start is accepted no earlier than the cycle after DONE.

## Configuration
- RF_DUMP_SKIP_ZERO_EN defined: register 0 (hardwired zero) is not emitted. In pair 0, SEND0 is bypassed: READ goes directly to SEND1. The stream carries NUM_REGS-1 beats, starting at addr 1. Timing for NUM_REGS=32: first beat in cycle 2, Done in cycle 48.
- Undefined: all NUM_REGS registers are emitted, starting at addr 0.

## Structure
- Shared package rf_pkg: RF_ADDR_W=5, RF_DATA_W=32, RF_NUM_REGS=32, and the rf_dump_state_t enum (IDLE, READ, SEND0, SEND1, DONE).
- Single module, no sub-modules. The holding registers and output mux are inline.

## Test plan
- Preload the register file with reg[i]=i·7+100 and hold OutReady=1. Pulse Start → 32 beats in address order 0..31 with data 100..317, Done in cycle 49, Busy high in cycles 1–48.
- OutReady toggles 1,0,1,0 during the dump → beats carry no duplicates and no drops. While OutValid=1 and OutReady=0, OutAddr and OutData stay stable. Done arrives one cycle after addr 31 is accepted.
- Write reg[8]=294 during SEND0 of pair 4 → addr 8 is emitted with the old value. In a second dump, addr 8 is emitted as 294.
- Start held high throughout the dump → exactly one dump of 32 beats. A second dump begins only after DONE.
- Drive rst_n=0 mid-dump while in SEND1 of pair 5 → OutValid, Busy, Done and ReadAddress1/2 read 0 immediately. After release, Start → beats begin at addr 0.
- RF_DUMP_SKIP_ZERO_EN defined → 31 beats, addr 1..31. No beat with addr 0 appears. Done arrives in cycle 48.
